ahb_bus_matrix_decoder_param: RTL and testbench
===============================================

// Module: ahb_bus_matrix_decoder_param
// PURPOSE
//  Parametrised slave-side decoder for the AHB bus matrix input stage: N base/limit address regions
//  over HADDR[31:10]; run-time region enable; integrated 2-cycle ERROR default slave; error
//  counter and faulting-address capture. Routes data-phase HREADYOUT/HRESP/HRDATA/HRUSER back.
// PARAMETERS
//  NUM_PORTS    4         output ports, 1..8
//  DATA_W       32        HRDATA width
//  RUSER_W      32        HRUSER width
//  REGION_BASE  {N{22'h0}} packed 22b region base per port, port k at [22k+21:22k]
//  REGION_LIMIT {N{22'h1f}} packed 22b inclusive region limit per port
//  ERR_CNT_W    8         error counter width
// PORTS
//  HCLK            in   1          AHB clock
//  HRESETn         in   1          async active-low reset
//  HREADYS         in   1          input-stage HREADY (data phase ends)
//  sel_dec         in   1          HSEL from input stage
//  decode_addr_dec in   22         HADDR[31:10]
//  trans_dec       in   2          HTRANS
//  port_en         in   N          1 = region k decodable; 0 = treated as unmapped
//  err_clr         in   1          sync clear of err_count
//  active_in       in   N          output-stage active per port
//  readyout_in     in   N          HREADYOUT per port
//  resp_in         in   2N         HRESP per port
//  rdata_in        in   DATA_W*N   HRDATA per port
//  ruser_in        in   RUSER_W*N  HRUSER per port
//  sel_out         out  N          HSEL per port (combinational)
//  active_dec      out  1          active of addressed port
//  HREADYOUTS      out  1          selected HREADYOUT
//  HRESPS          out  2          selected HRESP (2'b00 OKAY, 2'b01 ERROR)
//  HRDATAS         out  DATA_W     selected read data
//  HRUSERS         out  RUSER_W    selected read user data
//  err_count       out  ERR_CNT_W  saturating count of default-slave ERROR responses
//  err_addr        out  22         HADDR[31:10] of last unmapped NONSEQ/SEQ
// BEHAVIOUR
//  - Clock HCLK; reset HRESETn, asynchronous, active-low. No other clock/reset.
//  - Addr phase: addr_sel one-hot N+1 (bit N = default slave). Port k hit: port_en[k] &
//    BASE_k<=addr<=LIMIT_k; lowest k wins on overlap. No hit -> bit N.
//  - Hold: trans_dec==IDLE & data_sel==port k -> addr_sel=k, irrespective of addr.
//  - sel_out[k]=sel_dec&addr_sel[k]; dft select=sel_dec&addr_sel[N]. active_dec=active_in[k]
//    for selected k, 1 for default slave.
//  - data_sel reg: reset 0; loads addr_sel when HREADYS=1, else holds.
//  - Data-phase mux on data_sel: port k -> its readyout/resp/rdata/ruser; default -> FSM ready/resp,
//    rdata=ruser=0; data_sel==0 -> HREADYOUTS=1, HRESPS=OKAY, data 0 (never X).
//  - Default-slave FSM: IDLE,ERR1,ERR2; reset IDLE. IDLE: ready=1,OKAY.
//    IDLE->ERR1 on dft_sel&HREADYS&trans_dec[1]. ERR1: ready=0,ERROR -> ERR2.
//    ERR2: ready=1,ERROR -> ERR1 if new dft NONSEQ/SEQ with HREADYS, else IDLE.
//    IDLE/BUSY to default slave: zero-wait OKAY.
//  - err_count: reset 0; +1 on each entry to ERR1; saturates at all-ones; err_clr has priority
//    (simultaneous clr+entry -> 0).
//  - err_addr: reset 0; loads decode_addr_dec on same event that enters ERR1.
//  - port_en change mid-data-phase: affects addr phase only; data_sel unchanged.
//  - Reset mid-transfer: all regs to reset values next edge-independent; outputs as data_sel==0.
// STRUCTURE
//  - Package ahb_bmtx_pkg: HTRANS/HRESP encodings, FSM state enum, region packing helper fn.
//  - Sub-module ahb_bmtx_dflt_slv_fsm (FSM + err_count/err_addr); decode/mux in top.
// TESTING (N=4, regions 0x000000-0x00001F, 0x040000-0x04001F, 0x080000-0x0800FF, 0x0C0000-0x0C0000)
//  1 NONSEQ addr 0x040010, readyout_in[1]=0 two cycles -> sel_out=0010; HREADYOUTS low 2 cycles.
//  2 NONSEQ addr 0x100000 -> 1 cycle ready=0/ERROR, then ready=1/ERROR; err_count=1,
//    err_addr=0x100000; back-to-back unmapped NONSEQ -> ERR1 re-entered, err_count=2.
//  3 port_en[2]=0, NONSEQ 0x080010 -> default slave ERROR; port_en[2]=1 -> sel_out=0100, OKAY.
//  4 Transfer to port 0, then IDLE with addr 0x100000 -> sel_out stays 0001, no ERROR, count 0.
//  5 Overlap BASE1=0x000010 -> addr 0x000015 selects port 0.
//  6 Force 255 errors -> err_count=0xFF holds; err_clr with error entry same cycle -> 0.

Source files
------------

// File: rtl/ahb_bmtx_pkg.sv
// ahb_bmtx_pkg: shared encodings, default-slave state type and region unpacking helper
// for the AHB bus matrix decoder.
package ahb_bmtx_pkg;

    localparam int ADDR_W    = 22;
    localparam int MAX_PORTS = 8;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    // Region vectors are zero-extended to MAX_PORTS entries so one helper serves any port count.
    function automatic logic [ADDR_W-1:0] region_field(
        input logic [ADDR_W*MAX_PORTS-1:0] regions,
        input int                          k
    );
        return regions[ADDR_W*k +: ADDR_W];
    endfunction

endpackage

// File: rtl/ahb_bmtx_dflt_slv_fsm.sv
// ahb_bmtx_dflt_slv_fsm: default slave returning a two-cycle ERROR for unmapped transfers,
// with a saturating error counter and faulting-address capture.
//   HCLK, HRESETn    clock, async active-low reset
//   dft_sel          address phase targets the default slave
//   HREADYS          previous data phase completes this cycle
//   trans_active     HTRANS[1] (NONSEQ or SEQ)
//   decode_addr_dec  HADDR[31:10] of the address phase
//   err_clr          synchronous clear of err_count (wins over an increment)
//   ready, resp      default-slave HREADYOUT / HRESP
//   err_count        saturating count of ERROR responses started
//   err_addr         address of the most recent unmapped active transfer
module ahb_bmtx_dflt_slv_fsm
    import ahb_bmtx_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 dft_sel,
    input  logic                 HREADYS,
    input  logic                 trans_active,
    input  logic [ADDR_W-1:0]    decode_addr_dec,
    input  logic                 err_clr,
    output logic                 ready,
    output logic [1:0]           resp,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    err_addr
);

    ds_state_t state, state_nxt;
    logic      enter_err;

    // HREADYS is low throughout ERR1, so the state check only guards against a stray request.
    assign enter_err = dft_sel & HREADYS & trans_active & (state != DS_ERR1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= DS_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        resp      = RESP_OKAY;
        case (state)
            DS_IDLE: state_nxt = enter_err ? DS_ERR1 : DS_IDLE;
            DS_ERR1: begin
                ready     = 1'b0;
                resp      = RESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                resp      = RESP_ERROR;
                state_nxt = enter_err ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            if (err_clr)                        err_count <= '0;
            else if (enter_err && !(&err_count)) err_count <= err_count + 1'b1;
            if (enter_err) err_addr <= decode_addr_dec;
        end
    end

endmodule

// File: rtl/ahb_bus_matrix_decoder_param.sv
// ahb_bus_matrix_decoder_param: slave-side address decoder for an AHB bus matrix input stage.
// Decodes HADDR[31:10] into NUM_PORTS base/limit regions plus an integrated default slave, and
// routes the data-phase response of the selected port back to the input stage.
//   HCLK, HRESETn                 clock, async active-low reset
//   HREADYS                       input-stage HREADY
//   sel_dec, decode_addr_dec      HSEL and HADDR[31:10] from the input stage
//   trans_dec                     HTRANS
//   port_en                       run-time per-region enable
//   err_clr                       synchronous clear of err_count
//   active_in, readyout_in,
//   resp_in, rdata_in, ruser_in   per-port output-stage status and data-phase responses
//   sel_out, active_dec           per-port HSEL and active flag of the addressed port
//   HREADYOUTS, HRESPS,
//   HRDATAS, HRUSERS              selected data-phase response
//   err_count, err_addr           default-slave error statistics
module ahb_bus_matrix_decoder_param
    import ahb_bmtx_pkg::*;
#(
    parameter int                          NUM_PORTS    = 4,
    parameter int                          DATA_W       = 32,
    parameter int                          RUSER_W      = 32,
    parameter logic [ADDR_W*NUM_PORTS-1:0] REGION_BASE  = '0,
    parameter logic [ADDR_W*NUM_PORTS-1:0] REGION_LIMIT = {NUM_PORTS{22'h1f}},
    parameter int                          ERR_CNT_W    = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         HREADYS,
    input  logic                         sel_dec,
    input  logic [ADDR_W-1:0]            decode_addr_dec,
    input  logic [1:0]                   trans_dec,
    input  logic [NUM_PORTS-1:0]         port_en,
    input  logic                         err_clr,
    input  logic [NUM_PORTS-1:0]         active_in,
    input  logic [NUM_PORTS-1:0]         readyout_in,
    input  logic [2*NUM_PORTS-1:0]       resp_in,
    input  logic [DATA_W*NUM_PORTS-1:0]  rdata_in,
    input  logic [RUSER_W*NUM_PORTS-1:0] ruser_in,
    output logic [NUM_PORTS-1:0]         sel_out,
    output logic                         active_dec,
    output logic                         HREADYOUTS,
    output logic [1:0]                   HRESPS,
    output logic [DATA_W-1:0]            HRDATAS,
    output logic [RUSER_W-1:0]           HRUSERS,
    output logic [ERR_CNT_W-1:0]         err_count,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam logic [ADDR_W*MAX_PORTS-1:0] BASE_X  = (ADDR_W*MAX_PORTS)'(REGION_BASE);
    localparam logic [ADDR_W*MAX_PORTS-1:0] LIMIT_X = (ADDR_W*MAX_PORTS)'(REGION_LIMIT);

    // One-hot selects; bit NUM_PORTS is the default slave. data_sel == 0 only out of reset.
    logic [NUM_PORTS:0] addr_sel, data_sel;
    logic               hit_found, dft_sel, dft_ready;
    logic [1:0]         dft_resp;

    always_comb begin
        addr_sel  = '0;
        hit_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!hit_found && port_en[k] &&
                decode_addr_dec >= region_field(BASE_X, k) &&
                decode_addr_dec <= region_field(LIMIT_X, k)) begin
                addr_sel[k] = 1'b1;
                hit_found   = 1'b1;
            end
        end
        if (!hit_found) addr_sel[NUM_PORTS] = 1'b1;
        // An IDLE following a real-port transfer keeps that port selected so HSEL does not glitch.
        if (trans_dec == TRANS_IDLE && |data_sel[NUM_PORTS-1:0]) addr_sel = data_sel;
    end

    assign sel_out    = {NUM_PORTS{sel_dec}} & addr_sel[NUM_PORTS-1:0];
    assign dft_sel    = sel_dec & addr_sel[NUM_PORTS];
    assign active_dec = |(active_in & addr_sel[NUM_PORTS-1:0]) | addr_sel[NUM_PORTS];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     data_sel <= '0;
        else if (HREADYS) data_sel <= addr_sel;
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;
        HRDATAS    = '0;
        HRUSERS    = '0;
        if (data_sel[NUM_PORTS]) begin
            HREADYOUTS = dft_ready;
            HRESPS     = dft_resp;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (data_sel[k]) begin
                HREADYOUTS = readyout_in[k];
                HRESPS     = resp_in[2*k +: 2];
                HRDATAS    = rdata_in[DATA_W*k +: DATA_W];
                HRUSERS    = ruser_in[RUSER_W*k +: RUSER_W];
            end
        end
    end

    ahb_bmtx_dflt_slv_fsm #(.ERR_CNT_W(ERR_CNT_W)) u_dflt (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .dft_sel        (dft_sel),
        .HREADYS        (HREADYS),
        .trans_active   (trans_dec[1]),
        .decode_addr_dec(decode_addr_dec),
        .err_clr        (err_clr),
        .ready          (dft_ready),
        .resp           (dft_resp),
        .err_count      (err_count),
        .err_addr       (err_addr)
    );

endmodule

// File: tb/tb_ahb_bus_matrix_decoder_param.sv
// tb_ahb_bus_matrix_decoder_param: self-checking bench for ahb_bus_matrix_decoder_param.
module tb_ahb_bus_matrix_decoder_param;

    localparam logic [87:0] BASE    = {22'h0C0000, 22'h080000, 22'h040000, 22'h000000};
    localparam logic [87:0] BASE_OV = {22'h0C0000, 22'h080000, 22'h000010, 22'h000000};
    localparam logic [87:0] LIMIT   = {22'h0C0000, 22'h0800FF, 22'h04001F, 22'h00001F};
    localparam logic [1:0]  IDLE = 2'b00, NONSEQ = 2'b10;
    localparam int K_SEL = 0, K_RR = 1, K_RD = 2, K_RU = 3, K_CNT = 4, K_EA = 5, K_ACT = 6, K_OSEL = 7;

    logic         clk = 1'b0, rstn, sel, clr, hreadys;
    logic [21:0]  addr;
    logic [1:0]   trans;
    logic [3:0]   port_en, active_in, readyout_in;
    logic [7:0]   resp_in;
    logic [127:0] rdata_in, ruser_in;

    logic [3:0]  sel_out, sel_out_o;
    logic        active_dec, hreadyouts, active_dec_o, hreadyouts_o;
    logic [1:0]  hresps, hresps_o;
    logic [31:0] hrdatas, hrusers, hrdatas_o, hrusers_o;
    logic [7:0]  err_count, err_count_o;
    logic [21:0] err_addr, err_addr_o;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       nm;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [21:0] a;
        logic [1:0]  t;
        logic [3:0]  en;
        logic [3:0]  sel;
        logic [3:0]  osel;
        logic        act;
    } vec_t;
    vec_t tbl[$];

    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;
    assign hreadys = hreadyouts;

    ahb_bus_matrix_decoder_param #(.NUM_PORTS(4), .DATA_W(32), .RUSER_W(32),
        .REGION_BASE(BASE), .REGION_LIMIT(LIMIT), .ERR_CNT_W(8)) dut (
        .HCLK(clk), .HRESETn(rstn), .HREADYS(hreadys), .sel_dec(sel), .decode_addr_dec(addr),
        .trans_dec(trans), .port_en(port_en), .err_clr(clr), .active_in(active_in),
        .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
        .sel_out(sel_out), .active_dec(active_dec), .HREADYOUTS(hreadyouts), .HRESPS(hresps),
        .HRDATAS(hrdatas), .HRUSERS(hrusers), .err_count(err_count), .err_addr(err_addr));

    ahb_bus_matrix_decoder_param #(.NUM_PORTS(4), .DATA_W(32), .RUSER_W(32),
        .REGION_BASE(BASE_OV), .REGION_LIMIT(LIMIT), .ERR_CNT_W(8)) dut_ov (
        .HCLK(clk), .HRESETn(rstn), .HREADYS(hreadys), .sel_dec(sel), .decode_addr_dec(addr),
        .trans_dec(trans), .port_en(port_en), .err_clr(clr), .active_in(active_in),
        .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
        .sel_out(sel_out_o), .active_dec(active_dec_o), .HREADYOUTS(hreadyouts_o), .HRESPS(hresps_o),
        .HRDATAS(hrdatas_o), .HRUSERS(hrusers_o), .err_count(err_count_o), .err_addr(err_addr_o));

    function automatic logic [31:0] act(input int kind);
        case (kind)
            K_SEL:   return {28'h0, sel_out};
            K_RR:    return {29'h0, hreadyouts, hresps};
            K_RD:    return hrdatas;
            K_RU:    return hrusers;
            K_CNT:   return {24'h0, err_count};
            K_EA:    return {10'h0, err_addr};
            K_ACT:   return {31'h0, active_dec};
            default: return {28'h0, sel_out_o};
        endcase
    endfunction

    task automatic push_exp(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.nm   = nm;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] a;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = act(e.kind);
            compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h (t=%0t)", e.nm, a, e.val, $time);
            end
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [21:0] a);
        @(negedge clk);
        trans = t;
        addr  = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; sel = 1'b1; clr = 1'b0; addr = '0; trans = IDLE;
        port_en = 4'hF; active_in = 4'b1010; readyout_in = 4'hF; resp_in = '0;
        for (int k = 0; k < 4; k++) begin
            rdata_in[32*k +: 32] = 32'hD000_0000 + 32'(k);
            ruser_in[32*k +: 32] = 32'hE000_0000 + 32'(k);
        end
        tbl.push_back('{22'h000000, NONSEQ, 4'hF,    4'b0001, 4'b0001, 1'b0});
        tbl.push_back('{22'h00001F, NONSEQ, 4'hF,    4'b0001, 4'b0001, 1'b0});
        tbl.push_back('{22'h000020, NONSEQ, 4'hF,    4'b0000, 4'b0010, 1'b1});
        tbl.push_back('{22'h040010, NONSEQ, 4'hF,    4'b0010, 4'b0010, 1'b1});
        tbl.push_back('{22'h04001F, NONSEQ, 4'hF,    4'b0010, 4'b0010, 1'b1});
        tbl.push_back('{22'h040020, NONSEQ, 4'hF,    4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{22'h0800FF, NONSEQ, 4'hF,    4'b0100, 4'b0100, 1'b0});
        tbl.push_back('{22'h080100, NONSEQ, 4'hF,    4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{22'h0C0000, NONSEQ, 4'hF,    4'b1000, 4'b1000, 1'b1});
        tbl.push_back('{22'h0C0001, NONSEQ, 4'hF,    4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{22'h080010, NONSEQ, 4'b1011, 4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{22'h000015, NONSEQ, 4'hF,    4'b0001, 4'b0001, 1'b0});
        tbl.push_back('{22'h040010, NONSEQ, 4'b1101, 4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{22'h100000, NONSEQ, 4'hF,    4'b0000, 4'b0000, 1'b1});
        tbl.push_back('{22'h000015, IDLE,   4'hF,    4'b0001, 4'b0001, 1'b0});

        @(negedge clk);
        push_exp(K_RR, 32'b100, "reset_ready_okay");
        push_exp(K_RD, 32'h0, "reset_rdata");
        push_exp(K_RU, 32'h0, "reset_ruser");
        push_exp(K_CNT, 32'h0, "reset_err_count");
        push_exp(K_EA, 32'h0, "reset_err_addr");
        check_all();

        // Address decode table, applied while reset holds all registers idle.
        foreach (tbl[i]) begin
            drive(tbl[i].t, tbl[i].a);
            port_en = tbl[i].en;
            push_exp(K_SEL, {28'h0, tbl[i].sel}, $sformatf("tbl%0d_sel_out", i));
            push_exp(K_OSEL, {28'h0, tbl[i].osel}, $sformatf("tbl%0d_overlap_sel_out", i));
            push_exp(K_ACT, {31'h0, tbl[i].act}, $sformatf("tbl%0d_active_dec", i));
            push_exp(K_RR, 32'b100, $sformatf("tbl%0d_reset_ready", i));
            check_all();
        end

        drive(IDLE, 22'h0);
        rstn = 1'b1; port_en = 4'hF;

        // Port 1 with two wait states.
        drive(NONSEQ, 22'h040010);
        push_exp(K_SEL, 32'b0010, "p1_sel_out"); check_all();
        drive(IDLE, 22'h040010); readyout_in = 4'b1101;
        push_exp(K_SEL, 32'b0010, "p1_idle_hold_sel");
        push_exp(K_RR, 32'b000, "p1_wait1");
        push_exp(K_RD, 32'hD000_0001, "p1_rdata");
        push_exp(K_RU, 32'hE000_0001, "p1_ruser"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b000, "p1_wait2"); check_all();
        @(negedge clk); readyout_in = 4'hF;
        push_exp(K_RR, 32'b100, "p1_done");
        push_exp(K_RD, 32'hD000_0001, "p1_rdata_done"); check_all();

        // Unmapped NONSEQ, then back-to-back unmapped.
        drive(NONSEQ, 22'h100000);
        push_exp(K_SEL, 32'b0000, "unmapped_sel_out");
        push_exp(K_ACT, 32'h1, "unmapped_active"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b001, "err1_first");
        push_exp(K_RD, 32'h0, "err_rdata_zero");
        push_exp(K_RU, 32'h0, "err_ruser_zero");
        push_exp(K_CNT, 32'd1, "err_count_1");
        push_exp(K_EA, 32'h100000, "err_addr_100000"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b101, "err2_first");
        push_exp(K_CNT, 32'd1, "err_count_1_hold"); check_all();
        drive(IDLE, 22'h0);
        push_exp(K_SEL, 32'b0001, "after_err_idle_sel");
        push_exp(K_RR, 32'b001, "err1_second");
        push_exp(K_CNT, 32'd2, "err_count_2"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b101, "err2_second"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b100, "back_to_okay");
        push_exp(K_RD, 32'hD000_0000, "p0_rdata");
        push_exp(K_CNT, 32'd2, "err_count_2_hold"); check_all();

        // Disabled region goes to the default slave; re-enable routes normally.
        drive(NONSEQ, 22'h080010); port_en = 4'b1011;
        push_exp(K_SEL, 32'b0000, "disabled_p2_sel"); check_all();
        @(negedge clk); port_en = 4'hF;
        push_exp(K_SEL, 32'b0100, "enabled_p2_sel");
        push_exp(K_RR, 32'b001, "disabled_err1");
        push_exp(K_EA, 32'h080010, "err_addr_080010");
        push_exp(K_CNT, 32'd3, "err_count_3"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b101, "disabled_err2"); check_all();
        drive(IDLE, 22'h080010);
        push_exp(K_RR, 32'b100, "p2_okay");
        push_exp(K_RD, 32'hD000_0002, "p2_rdata"); check_all();
        @(negedge clk); port_en = 4'b1011;
        push_exp(K_SEL, 32'b0100, "p2_hold_despite_disable");
        push_exp(K_RR, 32'b100, "p2_data_unchanged_ready");
        push_exp(K_RD, 32'hD000_0002, "p2_data_unchanged_rdata"); check_all();

        // IDLE to an unmapped address after a port-0 transfer stays on port 0.
        drive(NONSEQ, 22'h0); port_en = 4'hF; clr = 1'b1;
        push_exp(K_SEL, 32'b0001, "p0_sel");
        push_exp(K_CNT, 32'd3, "count_before_clr"); check_all();
        drive(IDLE, 22'h100000); clr = 1'b0;
        push_exp(K_SEL, 32'b0001, "idle_hold_p0");
        push_exp(K_RR, 32'b100, "idle_hold_okay");
        push_exp(K_RD, 32'hD000_0000, "idle_hold_rdata");
        push_exp(K_CNT, 32'd0, "count_cleared"); check_all();
        @(negedge clk);
        push_exp(K_SEL, 32'b0001, "idle_hold_p0_2");
        push_exp(K_RR, 32'b100, "idle_no_error");
        push_exp(K_CNT, 32'd0, "idle_count_0"); check_all();

        // Saturation, then clear winning over a simultaneous error entry.
        for (int i = 0; i <= 600; i++) begin
            drive(NONSEQ, 22'h100000);
            clr = (i == 600);
            if (i == 200) push_exp(K_CNT, 32'd100, "count_100");
            if (i == 599) begin
                push_exp(K_CNT, 32'hFF, "count_saturated");
                push_exp(K_RR, 32'b001, "sat_err1");
            end
            if (i == 600) begin
                push_exp(K_CNT, 32'hFF, "count_saturated_hold");
                push_exp(K_RR, 32'b101, "sat_err2");
            end
            check_all();
        end
        drive(IDLE, 22'h0); clr = 1'b0;
        push_exp(K_CNT, 32'd0, "clr_beats_entry");
        push_exp(K_RR, 32'b001, "clr_entry_err1"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b101, "clr_entry_err2");
        push_exp(K_CNT, 32'd0, "clr_count_stays_0"); check_all();
        @(negedge clk);
        push_exp(K_RR, 32'b100, "clr_back_okay"); check_all();

        // Asynchronous reset in the middle of an error response.
        drive(NONSEQ, 22'h100000); check_all();
        @(negedge clk);
        push_exp(K_CNT, 32'd1, "pre_reset_count");
        push_exp(K_RR, 32'b001, "pre_reset_err1"); check_all();
        rstn = 1'b0;
        push_exp(K_RR, 32'b100, "midreset_ready_okay");
        push_exp(K_CNT, 32'd0, "midreset_count");
        push_exp(K_EA, 32'h0, "midreset_err_addr");
        push_exp(K_RD, 32'h0, "midreset_rdata"); check_all();
        drive(IDLE, 22'h0); rstn = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
